// File: rtl/payload_pkg.sv
// payload_pkg: definitions shared by the payload match reporter slice.
//   DEFAULT_NUM_ENGINES : default width of the engine match vector.
//   rpt_state_t         : reporter FSM state encoding.
package payload_pkg;

  localparam int DEFAULT_NUM_ENGINES = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    REPORT  = 2'd2
  } rpt_state_t;

endpackage

// File: rtl/payload_match_reporter_pend_prio_enc.sv
// pend_prio_enc: combinational lowest-set-bit encoder.
//   vec     in  NUM_ENGINES  vector to search
//   idx     out ID_W         index of the lowest set bit (0 when vec == 0)
//   any     out 1            at least one bit of vec is set
//   one_hot out 1            exactly one bit of vec is set
module pend_prio_enc
  import payload_pkg::*;
#(
  parameter int NUM_ENGINES = DEFAULT_NUM_ENGINES,
  parameter int ID_W        = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
  input  logic [NUM_ENGINES-1:0] vec,
  output logic [ID_W-1:0]        idx,
  output logic                   any,
  output logic                   one_hot
);

  // Priority search and population tests over the input vector.
  always_comb begin
    idx = {ID_W{1'b0}};
    // Scanning downward lets the lowest set bit win the final assignment.
    for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ID_W'(i);
      end else begin
        idx = idx;
      end
    end
    any = |vec;
    // v & (v-1) clears the lowest set bit; zero left over means one bit only.
    one_hot = any &&
              ((vec & (vec - NUM_ENGINES'(1))) == {NUM_ENGINES{1'b0}});
  end

endmodule

// File: rtl/payload_match_reporter.sv
// payload_match_reporter: snapshots the sticky engine match bits at end of
// packet and streams the matched engine indices, lowest first, as
// valid/ready beats tagged with a packet sequence number.
//   clk, rst            clock, synchronous active-high reset
//   sod, en, eod        packet framing (eod qualified by en)
//   match_in            engine out bits, bit i = engine i
//   rpt_valid/rpt_ready report beat handshake
//   rpt_id, rpt_seq     matched engine index, packet sequence number
//   rpt_none, rpt_last  empty-packet beat, final beat of the packet
//   busy                reporter not idle
//   overrun, sod_err    sticky error flags
module payload_match_reporter
  import payload_pkg::*;
#(
  parameter int NUM_ENGINES = DEFAULT_NUM_ENGINES,
  parameter int ID_W        = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1,
  parameter int SEQ_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sod,
  input  logic                   en,
  input  logic                   eod,
  input  logic [NUM_ENGINES-1:0] match_in,
  output logic                   rpt_valid,
  input  logic                   rpt_ready,
  output logic [ID_W-1:0]        rpt_id,
  output logic [SEQ_W-1:0]       rpt_seq,
  output logic                   rpt_none,
  output logic                   rpt_last,
  output logic                   busy,
  output logic                   overrun,
  output logic                   sod_err
);

  rpt_state_t             state_r;
  logic [NUM_ENGINES-1:0] pend_r;
  logic [SEQ_W-1:0]       seq_r;
  logic                   rpt_valid_r;
  logic [ID_W-1:0]        rpt_id_r;
  logic                   rpt_none_r;
  logic                   rpt_last_r;
  logic                   busy_r;
  logic                   overrun_r;
  logic                   sod_err_r;

  logic [NUM_ENGINES-1:0] pend_clr_s;
  logic [NUM_ENGINES-1:0] enc_in_s;
  logic [ID_W-1:0]        enc_idx_s;
  logic                   enc_any_s;
  logic                   enc_one_hot_s;
  logic                   eod_s;
  logic                   hs_s;

  assign eod_s = eod & en;
  assign hs_s  = rpt_valid_r & rpt_ready;

  // Pending set with the bit of the beat currently on the bus removed.
  assign pend_clr_s = pend_r & ~(NUM_ENGINES'(1) << rpt_id_r);

  // One encoder serves both the fresh snapshot and the post-handshake set,
  // so the next beat's fields can be registered one edge ahead.
  always_comb begin
    if (state_r == CAPTURE) begin
      enc_in_s = match_in;
    end else begin
      enc_in_s = pend_clr_s;
    end
  end

  pend_prio_enc #(
    .NUM_ENGINES (NUM_ENGINES),
    .ID_W        (ID_W)
  ) u_enc (
    .vec     (enc_in_s),
    .idx     (enc_idx_s),
    .any     (enc_any_s),
    .one_hot (enc_one_hot_s)
  );

  // Reporter FSM, snapshot register, sequence counter and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pend_r      <= {NUM_ENGINES{1'b0}};
      seq_r       <= {SEQ_W{1'b0}};
      rpt_valid_r <= 1'b0;
      rpt_id_r    <= {ID_W{1'b0}};
      rpt_none_r  <= 1'b0;
      rpt_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      overrun_r   <= 1'b0;
      sod_err_r   <= 1'b0;
    end else begin
      // A packet ending while a report is still in flight is dropped.
      if (eod_s && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end
      if (sod && (state_r == CAPTURE)) begin
        sod_err_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (eod_s) begin
            state_r <= CAPTURE;
            busy_r  <= 1'b1;
          end
        end
        CAPTURE: begin
          // match_in now holds the engines' state after the last byte.
          pend_r      <= match_in;
          state_r     <= REPORT;
          rpt_valid_r <= 1'b1;
          rpt_id_r    <= enc_idx_s;
          rpt_none_r  <= ~enc_any_s;
          rpt_last_r  <= enc_one_hot_s | ~enc_any_s;
        end
        REPORT: begin
          if (hs_s) begin
            if (rpt_last_r) begin
              state_r     <= IDLE;
              pend_r      <= {NUM_ENGINES{1'b0}};
              seq_r       <= seq_r + SEQ_W'(1);
              rpt_valid_r <= 1'b0;
              rpt_id_r    <= {ID_W{1'b0}};
              rpt_none_r  <= 1'b0;
              rpt_last_r  <= 1'b0;
              busy_r      <= 1'b0;
            end else begin
              pend_r     <= pend_clr_s;
              rpt_id_r   <= enc_idx_s;
              rpt_last_r <= enc_one_hot_s;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          rpt_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign rpt_valid = rpt_valid_r;
  assign rpt_id    = rpt_id_r;
  assign rpt_seq   = seq_r;
  assign rpt_none  = rpt_none_r;
  assign rpt_last  = rpt_last_r;
  assign busy      = busy_r;
  assign overrun   = overrun_r;
  assign sod_err   = sod_err_r;

endmodule

// File: tb/tb_payload_match_reporter.sv
// tb_payload_match_reporter: directed scoreboard bench for the reporter.
module tb_payload_match_reporter;

  localparam int NE = 32;
  localparam int IW = 5;
  localparam int SW = 8;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [SW-1:0] seq;
    logic          none;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          sod;
  logic          en;
  logic          eod;
  logic [NE-1:0] match_in;
  logic          rpt_valid;
  logic          rpt_ready;
  logic [IW-1:0] rpt_id;
  logic [SW-1:0] rpt_seq;
  logic          rpt_none;
  logic          rpt_last;
  logic          busy;
  logic          overrun;
  logic          sod_err;

  int            n_cmp = 0;
  int            n_bad = 0;
  beat_t         sb[$];
  logic [SW-1:0] tb_seq = 8'd0;
  logic          prev_stall = 1'b0;
  beat_t         held;

  payload_match_reporter #(
    .NUM_ENGINES (NE),
    .ID_W        (IW),
    .SEQ_W       (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sod       (sod),
    .en        (en),
    .eod       (eod),
    .match_in  (match_in),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_id    (rpt_id),
    .rpt_seq   (rpt_seq),
    .rpt_none  (rpt_none),
    .rpt_last  (rpt_last),
    .busy      (busy),
    .overrun   (overrun),
    .sod_err   (sod_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one beat per set bit ascending, or one "none" beat.
  task automatic push_pkt(input logic [NE-1:0] v);
    int hi;
    beat_t b;
    hi = -1;
    for (int i = 0; i < NE; i++) if (v[i]) hi = i;
    if (hi < 0) begin
      b.id = 5'd0; b.seq = tb_seq; b.none = 1'b1; b.last = 1'b1;
      sb.push_back(b);
    end else begin
      for (int i = 0; i < NE; i++) begin
        if (v[i]) begin
          b.id = IW'(i); b.seq = tb_seq; b.none = 1'b0; b.last = (i == hi);
          sb.push_back(b);
        end
      end
    end
    tb_seq = tb_seq + 8'd1;
  endtask

  task automatic wait_idle(input bit toggle);
    bit done;
    logic [3:0] pat;
    pat = 4'b1001;
    done = 1'b0;
    for (int k = 1; k < 300; k++) begin
      step();
      if (toggle) rpt_ready = pat[k % 4];
      @(negedge clk);
      if (!busy) begin
        done = 1'b1;
        break;
      end
    end
    rpt_ready = 1'b1;
    if (!done) chk("idle_timeout", {63'd0, busy}, 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic send_pkt(input logic [NE-1:0] v, input bit sod_cap, input bit toggle, input bit lat);
    push_pkt(v);
    eod = 1'b1; en = 1'b1; match_in = v;
    step();
    eod = 1'b0; en = 1'b0; sod = sod_cap;
    @(negedge clk);
    if (lat) chk("capture_busy_valid", {62'd0, busy, rpt_valid}, 64'd2);
    step();
    sod = 1'b0;
    match_in = $urandom;
    @(negedge clk);
    if (lat) chk("valid_latency", {63'd0, rpt_valid}, 64'd1);
    wait_idle(toggle);
  endtask

  // Scoreboard monitor: compares accepted beats and holds during stalls.
  always @(negedge clk) begin
    if (!rst && rpt_valid) begin
      if (prev_stall) chk("hold_stable", 64'({rpt_id, rpt_seq, rpt_none, rpt_last}), 64'(held));
      if (rpt_ready) begin
        n_cmp++;
        assert (sb.size() != 0) else begin
          n_bad++;
          $error("FAIL unexpected_beat observed=id%0d expected=no beat", rpt_id);
        end
        if (sb.size() != 0) begin
          chk("beat", 64'({rpt_id, rpt_seq, rpt_none, rpt_last}), 64'(sb.pop_front()));
        end
      end
      prev_stall <= !rpt_ready;
      held       <= {rpt_id, rpt_seq, rpt_none, rpt_last};
    end else begin
      prev_stall <= 1'b0;
    end
  end

  initial begin
    rst = 1'b1; sod = 1'b0; en = 1'b0; eod = 1'b0; match_in = 32'h0; rpt_ready = 1'b1;
    step(); step(); step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", 64'({rpt_valid, rpt_id, rpt_seq, rpt_none, rpt_last, busy, overrun, sod_err}), 64'd0);

    // Empty packet, then a three-match packet at full throughput.
    send_pkt(32'h0000_0000, 1'b0, 1'b0, 1'b1);
    send_pkt(32'h8000_0009, 1'b0, 1'b0, 1'b1);

    // Same vector under a stalling consumer.
    send_pkt(32'h8000_0009, 1'b0, 1'b1, 1'b1);

    // eod without en is ignored.
    step();
    eod = 1'b1; en = 1'b0;
    step(); step();
    eod = 1'b0;
    @(negedge clk);
    chk("eod_no_en_idle", {63'd0, busy}, 64'd0);

    // Second eod during REPORT is dropped; sod in REPORT is ignored.
    step();
    push_pkt(32'h0000_0006);
    eod = 1'b1; en = 1'b1; match_in = 32'h0000_0006;
    step();
    eod = 1'b0; en = 1'b0;
    step();
    eod = 1'b1; en = 1'b1; sod = 1'b1; match_in = 32'hFFFF_FFFF;
    step();
    eod = 1'b0; en = 1'b0; sod = 1'b0;
    @(negedge clk);
    wait_idle(1'b0);
    chk("overrun_set", {62'd0, overrun, sod_err}, 64'd2);
    send_pkt(32'h0000_0000, 1'b0, 1'b0, 1'b0);

    // sod in the CAPTURE cycle: snapshot still taken, flag set.
    send_pkt(32'h0001_0100, 1'b1, 1'b0, 1'b1);
    chk("sod_err_set", {63'd0, sod_err}, 64'd1);

    // Sequence number wraps.
    for (int i = 0; i < 256; i++) send_pkt(32'h0, 1'b0, 1'b0, 1'b0);
    chk("seq_wrapped", 64'(dut.rpt_seq), 64'(tb_seq));

    // Reset in the middle of a stalled report.
    step();
    rpt_ready = 1'b0;
    push_pkt(32'h0000_00F0);
    eod = 1'b1; en = 1'b1; match_in = 32'h0000_00F0;
    step();
    eod = 1'b0; en = 1'b0;
    step(); step();
    @(negedge clk);
    chk("stalled_valid", {63'd0, rpt_valid}, 64'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    tb_seq = 8'd0;
    @(negedge clk);
    chk("reset_mid_report", 64'({rpt_valid, rpt_id, rpt_seq, rpt_none, rpt_last, busy, overrun, sod_err}), 64'd0);
    step();
    rpt_ready = 1'b1;
    send_pkt(32'h0000_0001, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/payload_match_reporter.md
# payload_match_reporter

Downstream collector for the payload engine array. It samples the sticky per-rule `out` bits of all engines at end of packet and snapshots them. It then streams the indices of matched engines, lowest first, over a valid/ready interface tagged with a packet sequence number. It sits between the engine array and the alert/host interface logic.

## Interface
- `NUM_ENGINES`, default 32: number of engine match lines, range 1..256.
- `ID_W`, default `$clog2(NUM_ENGINES)` (min 1): width of the engine index.
- `SEQ_W`, default 8: width of the packet sequence number.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sod`  in  1  start-of-data strobe; the same signal clears the engines.
- `en`  in  1  byte-enable; the same signal drives the engines.
- `eod`  in  1  last-byte strobe; qualified by `en`.
- `match_in`  in  NUM_ENGINES  engine `out` bits; bit i = engine i.
- `rpt_valid`  out  1  report beat valid.
- `rpt_ready`  in  1  consumer accepts the beat.
- `rpt_id`  out  ID_W  matched engine index.
- `rpt_seq`  out  SEQ_W  packet sequence number.
- `rpt_none`  out  1  the packet had no match; `rpt_id` = 0.
- `rpt_last`  out  1  final beat for this packet.
- `busy`  out  1  state ≠ IDLE.
- `overrun`  out  1  sticky: an `eod` arrived while not IDLE.
- `sod_err`  out  1  sticky: `sod` asserted during CAPTURE.

## Operation
- States: IDLE, CAPTURE, REPORT.
- IDLE → CAPTURE on `eod & en`.
- CAPTURE lasts exactly one cycle. During it `match_in` reflects the last byte. At the end of CAPTURE, `pend <= match_in` and the state goes to REPORT.
- REPORT:
  - `rpt_id` = lowest set index in `pend`.
  - `rpt_last` = 1 when exactly one bit of `pend` is set.
  - On handshake (`rpt_valid & rpt_ready`), that bit is cleared.
  - After the handshake of the `rpt_last` beat: state → IDLE and `seq` increments.
  - `seq` wraps modulo 2^SEQ_W.
- Empty snapshot (`pend == 0`): one beat with `rpt_none=1`, `rpt_last=1`, `rpt_id=0`.
- Output stability: `rpt_id`, `rpt_seq`, `rpt_none` and `rpt_last` stay stable while `rpt_valid & !rpt_ready`.
- `eod & en` while in CAPTURE or REPORT: the packet is dropped, `overrun` is set, `seq` is unchanged, and the current report continues unaffected.
- `sod` during CAPTURE: the snapshot is still taken and `sod_err` is set. `sod` in IDLE or REPORT is ignored.
- `eod` without `en`: ignored.
- `match_in` is ignored outside CAPTURE.

## Timing
- Reset values: `rpt_valid` 0, `rpt_id` 0, `rpt_seq` 0, `rpt_none` 0, `rpt_last` 0, `busy` 0, `overrun` 0, `sod_err` 0. Internal state: `pend` 0, `seq` 0, state IDLE.
- `rst` wins over every other input in the same cycle. `rst` mid-REPORT drops the pending report immediately and clears the sticky flags.
- Latency: `eod & en` sampled at edge E0 → CAPTURE. Snapshot taken at edge E1. `rpt_valid`=1 in the cycle after E1, i.e. two cycles after the `eod` cycle.
- Throughput: one beat per cycle with `rpt_ready` held high.
- `busy` is registered. It is high from the cycle after the `eod` edge through the cycle of the last handshake.
- Back-to-back `eod` with no `overrun` requires: a gap of K+2 cycles between `eod`s (K = match count, min 1), with `rpt_ready` tied high.

## Structure
- Shared package `payload_pkg`:
  - `rpt_state_t` enum {IDLE, CAPTURE, REPORT}.
  - `NUM_ENGINES` default constant.
- Sub-module `pend_prio_enc`: combinational lowest-set-bit encoder over NUM_ENGINES bits. Outputs: index, `any`, `one_hot` (exactly one set, for `rpt_last`).

## Test plan
- NUM_ENGINES=32, `match_in`=0x0000_0000 at `eod`, `rpt_ready`=1 → exactly one beat: `rpt_none`=1, `rpt_last`=1, `rpt_seq`=0. `busy` falls after that beat.
- `match_in`=0x8000_0009, `rpt_ready`=1 → beats with `rpt_id` 0, 3, 31 on consecutive cycles. `rpt_last` on 31 only. `rpt_valid` first high 2 cycles after `eod`.
- Same vector, `rpt_ready` toggling 1,0,0,1,… → no beat lost or duplicated, and outputs are held during stalls.
- Second `eod` during REPORT → `overrun`=1, the first report completes intact, the next accepted packet carries `rpt_seq`=1.
- 256 empty packets → `rpt_seq` goes 0..255, then wraps to 0.
- `rst` pulsed mid-REPORT with 0x0000_00F0 pending → next cycle `rpt_valid`=0 and all outputs at reset values. `sod` in the CAPTURE cycle → `sod_err`=1.
